// File: rtl/arp_rewrite.sv
// Purpose: resolve next-hop MAC from a 32-entry ARP table, rewrite the first beat (MAC/TTL/csum/dst port) or divert to CPU.
// Latency: first beat leaves 2 cycles after acceptance (one bubble per packet); later beats pass through combinationally.
// Backpressure: header held stable in EMIT until M_AXIS_TREADY; in PASS S_AXIS_TREADY follows M_AXIS_TREADY.
module arp_rewrite #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int SRC_PORT_POS         = 16,
   parameter int DST_PORT_POS         = 24
) (
   input  logic                                AXI_ACLK,
   input  logic                                AXI_RESET,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
   input  logic                                S_AXIS_TVALID,
   input  logic                                S_AXIS_TLAST,
   output logic                                S_AXIS_TREADY,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
   output logic                                M_AXIS_TVALID,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   input  logic                                lpm_hit,
   input  logic [31:0]                         nh_reg,
   input  logic [31:0]                         oq_reg,
   input  logic                                arp_wr_en,
   input  logic [4:0]                          arp_wr_index,
   input  logic                                arp_wr_valid,
   input  logic [31:0]                         arp_wr_ip,
   input  logic [47:0]                         arp_wr_mac,
   input  logic                                counters_clr,
   output logic [31:0]                         arp_miss_count,
   output logic [31:0]                         lpm_miss_count,
   output logic [31:0]                         ttl_exp_count,
   output logic [31:0]                         fwd_count
);

   localparam int ARP_ENTRIES = 32;

   typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_EMIT, ST_PASS} state_t;

   state_t state_q, state_d;

   // captured first beat
   logic [C_S_AXIS_DATA_WIDTH-1:0]   hdr_tdata_q;
   logic [C_S_AXIS_DATA_WIDTH/8-1:0] hdr_tstrb_q;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]  hdr_tuser_q;
   logic                             hdr_tlast_q;

   // lookup results
   logic        lpm_hit_q;
   logic [31:0] oq_q;
   logic        arp_hit_q;
   logic [47:0] arp_mac_q;

   // ARP table
   logic [ARP_ENTRIES-1:0] arp_vld_q;
   logic [31:0]            arp_ip_q  [ARP_ENTRIES];
   logic [47:0]            arp_mac_tbl_q [ARP_ENTRIES];

   logic [31:0] arp_miss_cnt_q, lpm_miss_cnt_q, ttl_exp_cnt_q, fwd_cnt_q;

   logic        s_hs_idle;
   logic        emit_hs;
   logic        lk_hit;
   logic [47:0] lk_mac;
   logic [7:0]  dst_in, src_in, cpu_dst, fwd_dst;
   logic        dec_pass, dec_lpm, dec_ttl, dec_arp, dec_fwd;
   logic [7:0]  ttl_in;
   logic [16:0] csum_sum;
   logic [15:0] csum_new;
   logic [C_S_AXIS_DATA_WIDTH-1:0]  emit_tdata;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] emit_tuser;

   assign s_hs_idle = (state_q == ST_IDLE) && S_AXIS_TVALID && !AXI_RESET;
   assign emit_hs   = (state_q == ST_EMIT) && M_AXIS_TREADY;

   // state register
   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // next-state: one lookup cycle, then hold header until taken, then stream the rest
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (S_AXIS_TVALID) state_d = ST_LOOKUP;
         ST_LOOKUP: state_d = ST_EMIT;
         ST_EMIT:   if (M_AXIS_TREADY) state_d = hdr_tlast_q ? ST_IDLE : ST_PASS;
         ST_PASS:   if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // capture beat 0 on the IDLE handshake
   always_ff @(posedge AXI_ACLK) begin
      if (s_hs_idle) begin
         hdr_tdata_q <= S_AXIS_TDATA;
         hdr_tstrb_q <= S_AXIS_TSTRB;
         hdr_tuser_q <= S_AXIS_TUSER;
         hdr_tlast_q <= S_AXIS_TLAST;
      end
   end

   // parallel match; scanning downward lets the lowest matching index win
   always_comb begin
      lk_hit = 1'b0;
      lk_mac = '0;
      for (int i = ARP_ENTRIES - 1; i >= 0; i--) begin
         if (arp_vld_q[i] && (arp_ip_q[i] == nh_reg)) begin
            lk_hit = 1'b1;
            lk_mac = arp_mac_tbl_q[i];
         end
      end
   end

   // LPM results arrive one cycle after beat 0, so sample them in LOOKUP
   always_ff @(posedge AXI_ACLK) begin
      if (state_q == ST_LOOKUP) begin
         lpm_hit_q <= lpm_hit;
         oq_q      <= oq_reg;
         arp_hit_q <= lk_hit;
         arp_mac_q <= lk_mac;
      end
   end

   // ARP valid bits; the lookup reads pre-write contents, so a LOOKUP-cycle write is not seen
   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET)      arp_vld_q <= '0;
      else if (arp_wr_en) arp_vld_q[arp_wr_index] <= arp_wr_valid;
   end

   // ARP ip/mac storage, meaningful only where the valid bit is set
   always_ff @(posedge AXI_ACLK) begin
      if (arp_wr_en) begin
         arp_ip_q[arp_wr_index]      <= arp_wr_ip;
         arp_mac_tbl_q[arp_wr_index] <= arp_wr_mac;
      end
   end

   assign dst_in   = hdr_tuser_q[DST_PORT_POS +: 8];
   assign src_in   = hdr_tuser_q[SRC_PORT_POS +: 8];
   assign ttl_in   = hdr_tdata_q[79:72];
   // TTL drops by one, so the checksum rises by 0x0100 in ones-complement
   assign csum_sum = {1'b0, hdr_tdata_q[63:48]} + 17'h0_0100;
   assign csum_new = csum_sum[15:0] + {15'b0, csum_sum[16]};

   // priority decision: already steered to CPU, LPM miss, TTL expiry, ARP miss, forward
   always_comb begin
      dec_pass = 1'b0;
      dec_lpm  = 1'b0;
      dec_ttl  = 1'b0;
      dec_arp  = 1'b0;
      dec_fwd  = 1'b0;
      if (dst_in[1] || dst_in[3] || dst_in[5] || dst_in[7]) dec_pass = 1'b1;
      else if (!lpm_hit_q || (oq_q > 32'd4))                 dec_lpm  = 1'b1;
      else if (ttl_in <= 8'd1)                               dec_ttl  = 1'b1;
      else if (!arp_hit_q)                                   dec_arp  = 1'b1;
      else                                                   dec_fwd  = 1'b1;
   end

   // CPU queue sits on the odd bit next to the source MAC port
   always_comb begin
      cpu_dst = 8'h02;
      if      (src_in[0]) cpu_dst = 8'h02;
      else if (src_in[2]) cpu_dst = 8'h08;
      else if (src_in[4]) cpu_dst = 8'h20;
      else if (src_in[6]) cpu_dst = 8'h80;
   end

   // output-queue index to one-hot destination
   always_comb begin
      fwd_dst = 8'h01;
      case (oq_q)
         32'd0:   fwd_dst = 8'h01;
         32'd1:   fwd_dst = 8'h04;
         32'd2:   fwd_dst = 8'h10;
         32'd3:   fwd_dst = 8'h40;
         32'd4:   fwd_dst = 8'h02;
         default: fwd_dst = 8'h01;
      endcase
   end

   // rewritten first beat
   always_comb begin
      emit_tdata = hdr_tdata_q;
      emit_tuser = hdr_tuser_q;
      if (dec_fwd) begin
         emit_tdata[255:208]              = arp_mac_q;
         emit_tdata[79:72]                = ttl_in - 8'd1;
         emit_tdata[63:48]                = csum_new;
         emit_tuser[DST_PORT_POS +: 8]    = fwd_dst;
      end else if (dec_lpm || dec_ttl || dec_arp) begin
         emit_tuser[DST_PORT_POS +: 8]    = cpu_dst;
      end
   end

   // output steering per state
   always_comb begin
      S_AXIS_TREADY = 1'b0;
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TDATA  = hdr_tdata_q;
      M_AXIS_TSTRB  = hdr_tstrb_q;
      M_AXIS_TUSER  = hdr_tuser_q;
      M_AXIS_TLAST  = hdr_tlast_q;
      case (state_q)
         ST_IDLE: S_AXIS_TREADY = !AXI_RESET;
         ST_EMIT: begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TDATA  = emit_tdata;
            M_AXIS_TUSER  = emit_tuser;
         end
         ST_PASS: begin
            S_AXIS_TREADY = M_AXIS_TREADY;
            M_AXIS_TVALID = S_AXIS_TVALID;
            M_AXIS_TDATA  = S_AXIS_TDATA;
            M_AXIS_TSTRB  = S_AXIS_TSTRB;
            M_AXIS_TUSER  = S_AXIS_TUSER;
            M_AXIS_TLAST  = S_AXIS_TLAST;
         end
         default: ;
      endcase
   end

   // per-cause counters, bumped once per packet when the header is taken; clear wins
   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET || counters_clr) begin
         arp_miss_cnt_q <= '0;
         lpm_miss_cnt_q <= '0;
         ttl_exp_cnt_q  <= '0;
         fwd_cnt_q      <= '0;
      end else if (emit_hs) begin
         if (dec_arp) arp_miss_cnt_q <= arp_miss_cnt_q + 32'd1;
         if (dec_lpm) lpm_miss_cnt_q <= lpm_miss_cnt_q + 32'd1;
         if (dec_ttl) ttl_exp_cnt_q  <= ttl_exp_cnt_q + 32'd1;
         if (dec_fwd) fwd_cnt_q      <= fwd_cnt_q + 32'd1;
      end
   end

   assign arp_miss_count = arp_miss_cnt_q;
   assign lpm_miss_count = lpm_miss_cnt_q;
   assign ttl_exp_count  = ttl_exp_cnt_q;
   assign fwd_count      = fwd_cnt_q;

endmodule

// File: tb/tb_arp_rewrite.sv
// Purpose: directed plus randomized packets against a table-driven reference of the ARP rewrite stage.
// Latency: checks beat 0 two cycles after acceptance and pass-through beats in the same cycle.
// Backpressure: stalls M_AXIS_TREADY in EMIT and checks the held beat and S_AXIS_TREADY.
module tb_arp_rewrite;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] s_tdata;
   logic [31:0]  s_tstrb;
   logic [127:0] s_tuser;
   logic         s_tvalid, s_tlast, s_tready;
   logic [255:0] m_tdata;
   logic [31:0]  m_tstrb;
   logic [127:0] m_tuser;
   logic         m_tvalid, m_tlast, m_tready;
   logic         lpm_hit;
   logic [31:0]  nh_reg, oq_reg;
   logic         arp_wr_en, arp_wr_valid;
   logic [4:0]   arp_wr_index;
   logic [31:0]  arp_wr_ip;
   logic [47:0]  arp_wr_mac;
   logic         counters_clr;
   logic [31:0]  arp_miss_count, lpm_miss_count, ttl_exp_count, fwd_count;

   always #5 clk = ~clk;

   arp_rewrite dut (
      .AXI_ACLK(clk), .AXI_RESET(rst),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
      .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
      .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
      .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
      .lpm_hit(lpm_hit), .nh_reg(nh_reg), .oq_reg(oq_reg),
      .arp_wr_en(arp_wr_en), .arp_wr_index(arp_wr_index), .arp_wr_valid(arp_wr_valid),
      .arp_wr_ip(arp_wr_ip), .arp_wr_mac(arp_wr_mac), .counters_clr(counters_clr),
      .arp_miss_count(arp_miss_count), .lpm_miss_count(lpm_miss_count),
      .ttl_exp_count(ttl_exp_count), .fwd_count(fwd_count)
   );

   int ncmp = 0;
   int nmis = 0;

   // reference state
   bit          m_vld [32];
   logic [31:0] m_ip  [32];
   logic [47:0] m_mac [32];
   logic [31:0] e_lpm, e_ttl, e_arp, e_fwd;
   logic [7:0]  fwd_map [5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h02};
   logic [31:0] ip_pool [6] = '{32'h0A000101, 32'h0A000202, 32'hC0A80001, 32'hC0A80002, 32'h08080808, 32'h0B000001};

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_counters(input string tag);
      check({tag, ".lpm"}, 256'(lpm_miss_count), 256'(e_lpm));
      check({tag, ".ttl"}, 256'(ttl_exp_count),  256'(e_ttl));
      check({tag, ".arp"}, 256'(arp_miss_count), 256'(e_arp));
      check({tag, ".fwd"}, 256'(fwd_count),      256'(e_fwd));
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [255:0] mk_hdr(input logic [7:0] ttl, input logic [15:0] csum);
      logic [255:0] v;
      v = rnd256();
      v[79:72] = ttl;
      v[63:48] = csum;
      return v;
   endfunction

   function automatic logic [127:0] mk_user(input int src_bit, input logic [7:0] dst);
      logic [127:0] v;
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      v[23:16] = 8'h01 << src_bit;
      v[31:24] = dst;
      return v;
   endfunction

   task automatic arp_write(input int idx, input bit v, input logic [31:0] ip, input logic [47:0] mac);
      arp_wr_en = 1'b1; arp_wr_index = 5'(idx); arp_wr_valid = v; arp_wr_ip = ip; arp_wr_mac = mac;
      tick();
      arp_wr_en = 1'b0;
      m_vld[idx] = v; m_ip[idx] = ip; m_mac[idx] = mac;
   endtask

   // reference: first-beat result from the forwarding rules; cause 0 none,1 lpm,2 ttl,3 arp,4 fwd
   task automatic model_beat0(input logic [255:0] d, input logic [127:0] u, input logic hit,
                              input logic [31:0] nh, input logic [31:0] oq,
                              output logic [255:0] od, output logic [127:0] ou, output int cause);
      logic [7:0] dst, src, cpu;
      int idx, s;
      dst = u[31:24]; src = u[23:16];
      od = d; ou = u; idx = -1;
      for (int i = 0; i < 32; i++) if (idx < 0 && m_vld[i] && m_ip[i] == nh) idx = i;
      if ((dst & 8'hAA) != 8'h00)        cause = 0;
      else if (!hit || oq > 4)           cause = 1;
      else if (d[79:72] <= 8'd1)         cause = 2;
      else if (idx < 0)                  cause = 3;
      else                               cause = 4;
      cpu = 8'h02;
      for (int b = 6; b >= 0; b -= 2) if (src[b]) cpu = 8'h01 << (b + 1);
      if (cause == 4) begin
         od[255:208] = m_mac[idx];
         od[79:72]   = d[79:72] - 8'd1;
         s = int'(d[63:48]) + 256;
         if (s > 65535) s -= 65535;
         od[63:48]   = s[15:0];
         ou[31:24]   = fwd_map[oq];
      end else if (cause != 0) begin
         ou[31:24]   = cpu;
      end
   endtask

   task automatic send_pkt(input string tag, input int nbeats, input logic hit, input logic [31:0] nh,
                           input logic [31:0] oq, input logic [255:0] d0, input logic [127:0] u0,
                           input int stall, input int inval_idx, input bit clr_at_emit,
                           input bit rst_in_pass, input bit b2b);
      logic [255:0] bd[$];
      logic [127:0] bu[$];
      logic [31:0]  bs[$];
      logic [255:0] exp_d;
      logic [127:0] exp_u;
      int cause, waited;
      bit accepted;
      bd.push_back(d0); bu.push_back(u0); bs.push_back($urandom());
      for (int i = 1; i < nbeats; i++) begin
         bd.push_back(rnd256());
         bu.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
         bs.push_back($urandom());
      end
      model_beat0(d0, u0, hit, nh, oq, exp_d, exp_u, cause);

      m_tready = 1'b0;
      s_tvalid = 1'b1; s_tdata = bd[0]; s_tuser = bu[0]; s_tstrb = bs[0]; s_tlast = (nbeats == 1);
      waited = 0; accepted = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (s_tready) begin accepted = 1'b1; break; end
         waited++;
         @(posedge clk); #1;
      end
      if (!accepted) begin
         check({tag, ".accept_timeout"}, 256'(0), 256'(1));
         s_tvalid = 1'b0;
         return;
      end
      if (b2b) check({tag, ".b2b_wait"}, 256'(waited), 256'(0));
      tick();

      // LOOKUP: LPM results presented now
      lpm_hit = hit; nh_reg = nh; oq_reg = oq;
      if (nbeats > 1) begin
         s_tdata = bd[1]; s_tuser = bu[1]; s_tstrb = bs[1]; s_tlast = (nbeats == 2);
      end else s_tvalid = 1'b0;
      if (inval_idx >= 0) begin
         arp_wr_en = 1'b1; arp_wr_index = 5'(inval_idx); arp_wr_valid = 1'b0;
         arp_wr_ip = m_ip[inval_idx]; arp_wr_mac = 48'h0;
      end
      @(negedge clk);
      check({tag, ".bubble_mvld"}, 256'(m_tvalid), 256'(0));
      check({tag, ".lookup_srdy"}, 256'(s_tready), 256'(0));
      tick();
      arp_wr_en = 1'b0;
      if (inval_idx >= 0) m_vld[inval_idx] = 1'b0;
      lpm_hit = ~hit; nh_reg = $urandom(); oq_reg = $urandom();

      // EMIT
      for (int k = 0; k <= stall; k++) begin
         if (k == stall) begin
            m_tready = 1'b1;
            counters_clr = clr_at_emit;
         end
         @(negedge clk);
         check({tag, ".b0_vld"},   256'(m_tvalid), 256'(1));
         check({tag, ".b0_data"},  m_tdata, exp_d);
         check({tag, ".b0_user"},  256'(m_tuser), 256'(exp_u));
         check({tag, ".b0_strb"},  256'(m_tstrb), 256'(bs[0]));
         check({tag, ".b0_last"},  256'(m_tlast), 256'(nbeats == 1));
         check({tag, ".emit_srdy"}, 256'(s_tready), 256'(0));
         tick();
      end
      counters_clr = 1'b0;
      if (clr_at_emit) begin
         e_lpm = 0; e_ttl = 0; e_arp = 0; e_fwd = 0;
      end else begin
         case (cause)
            1: e_lpm++;
            2: e_ttl++;
            3: e_arp++;
            4: e_fwd++;
            default: ;
         endcase
      end
      check_counters({tag, ".cnt"});

      // PASS
      for (int i = 1; i < nbeats; i++) begin
         if (rst_in_pass) begin
            rst = 1'b1;
            #1;
            check({tag, ".rst_mvld"}, 256'(m_tvalid), 256'(0));
            check({tag, ".rst_srdy"}, 256'(s_tready), 256'(0));
            e_lpm = 0; e_ttl = 0; e_arp = 0; e_fwd = 0;
            for (int j = 0; j < 32; j++) m_vld[j] = 1'b0;
            check_counters({tag, ".rst_cnt"});
            s_tvalid = 1'b0;
            tick();
            rst = 1'b0;
            tick();
            return;
         end
         @(negedge clk);
         check({tag, ".pass_vld"},  256'(m_tvalid), 256'(1));
         check({tag, ".pass_data"}, m_tdata, bd[i]);
         check({tag, ".pass_user"}, 256'(m_tuser), 256'(bu[i]));
         check({tag, ".pass_last"}, 256'(m_tlast), 256'(i == nbeats - 1));
         check({tag, ".pass_srdy"}, 256'(s_tready), 256'(1));
         tick();
         if (i + 1 < nbeats) begin
            s_tdata = bd[i+1]; s_tuser = bu[i+1]; s_tstrb = bs[i+1]; s_tlast = (i + 1 == nbeats - 1);
         end else s_tvalid = 1'b0;
      end
   endtask

   initial begin
      logic [255:0] h;
      int nb, st, sb;
      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tlast = 1'b0;
      m_tready = 1'b0; lpm_hit = 1'b0; nh_reg = '0; oq_reg = '0; arp_wr_en = 1'b0;
      arp_wr_index = '0; arp_wr_valid = 1'b0; arp_wr_ip = '0; arp_wr_mac = '0; counters_clr = 1'b0;
      e_lpm = 0; e_ttl = 0; e_arp = 0; e_fwd = 0;
      for (int i = 0; i < 32; i++) begin m_vld[i] = 1'b0; m_ip[i] = '0; m_mac[i] = '0; end

      // reset state
      repeat (3) @(negedge clk);
      check("rst.srdy", 256'(s_tready), 256'(0));
      check("rst.mvld", 256'(m_tvalid), 256'(0));
      check_counters("rst");
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("idle.srdy", 256'(s_tready), 256'(1));
      tick();

      // forward with known values, then end-around carry, back-to-back
      arp_write(3, 1'b1, 32'h0A000101, 48'h001122334455);
      send_pkt("fwd", 3, 1'b1, 32'h0A000101, 2, mk_hdr(8'h40, 16'hB861), mk_user(0, 8'h00), 0, -1, 0, 0, 0);
      send_pkt("carry", 2, 1'b1, 32'h0A000101, 0, mk_hdr(8'h10, 16'hFFAA), mk_user(2, 8'h00), 0, -1, 0, 0, 1);
      // to-CPU causes and pre-steered packet
      send_pkt("lpm_miss", 2, 1'b0, 32'h0A000101, 1, mk_hdr(8'h40, 16'h1234), mk_user(4, 8'h00), 0, -1, 0, 0, 0);
      send_pkt("arp_miss", 2, 1'b1, 32'h0B000001, 1, mk_hdr(8'h40, 16'h1234), mk_user(4, 8'h00), 0, -1, 0, 0, 0);
      send_pkt("ttl_exp", 2, 1'b1, 32'h0A000101, 3, mk_hdr(8'h01, 16'h4321), mk_user(6, 8'h00), 0, -1, 0, 0, 0);
      send_pkt("presteer", 2, 1'b1, 32'h0A000101, 3, mk_hdr(8'h40, 16'h4321), mk_user(0, 8'h02), 0, -1, 0, 0, 0);
      send_pkt("oq_big", 1, 1'b1, 32'h0A000101, 5, mk_hdr(8'h40, 16'h0), mk_user(3, 8'h00), 0, -1, 0, 0, 0);
      // stall in EMIT on a single-beat packet, then IDLE
      send_pkt("stall", 1, 1'b1, 32'h0A000101, 4, mk_hdr(8'h80, 16'h0001), mk_user(0, 8'h00), 5, -1, 0, 0, 0);
      @(negedge clk);
      check("stall.idle_srdy", 256'(s_tready), 256'(1));
      check("stall.idle_mvld", 256'(m_tvalid), 256'(0));
      tick();
      for (int i = 0; i < 3; i++)
         send_pkt("b2b", 1 + i, 1'b1, 32'h0A000101, i, mk_hdr(8'h22, 16'(i)), mk_user(2, 8'h00), 0, -1, 0, 0, i > 0);
      // lowest matching index wins
      arp_write(7,  1'b1, 32'hC0A80001, 48'hAAAAAAAAAA07);
      arp_write(20, 1'b1, 32'hC0A80001, 48'hBBBBBBBBBB20);
      send_pkt("lowest", 1, 1'b1, 32'hC0A80001, 3, mk_hdr(8'h05, 16'hABCD), mk_user(0, 8'h00), 0, -1, 0, 0, 0);
      // invalidate during LOOKUP: this packet still forwards, next misses
      send_pkt("inval", 2, 1'b1, 32'h0A000101, 1, mk_hdr(8'h40, 16'h0), mk_user(0, 8'h00), 0, 3, 0, 0, 0);
      send_pkt("after_inval", 1, 1'b1, 32'h0A000101, 1, mk_hdr(8'h40, 16'h0), mk_user(6, 8'h00), 0, -1, 0, 0, 0);
      // clear coincident with increment
      send_pkt("clr", 1, 1'b1, 32'hC0A80001, 0, mk_hdr(8'h40, 16'h0), mk_user(0, 8'h00), 1, -1, 1, 0, 0);

      // randomized traffic
      for (int i = 0; i < 10; i++)
         arp_write($urandom_range(0, 31), 1'($urandom_range(0, 3) != 0), ip_pool[$urandom_range(0, 4)], {$urandom(), 16'($urandom())});
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: h = mk_hdr(8'h00, 16'($urandom()));
            1: h = mk_hdr(8'h01, 16'($urandom()));
            2: h = mk_hdr(8'h02, 16'hFF00 | 16'($urandom_range(0, 255)));
            default: h = mk_hdr(8'($urandom()), 16'($urandom()));
         endcase
         nb = $urandom_range(1, 4);
         st = $urandom_range(0, 2);
         sb = $urandom_range(0, 7);
         send_pkt("rnd", nb, 1'($urandom_range(0, 4) != 0), ip_pool[$urandom_range(0, 5)],
                  $urandom_range(0, 6), h,
                  mk_user(sb, ($urandom_range(0, 4) == 0) ? 8'($urandom()) : 8'h00),
                  st, -1, 0, 0, 0);
      end

      // reset while in PASS, then recovery with an empty table
      send_pkt("rst_pass", 3, 1'b1, ip_pool[0], 1, mk_hdr(8'h40, 16'h0), mk_user(0, 8'h00), 0, -1, 0, 1, 0);
      send_pkt("post_rst", 2, 1'b1, ip_pool[0], 1, mk_hdr(8'h40, 16'h0), mk_user(2, 8'h00), 0, -1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
